// File: rtl/sm83_alu_nibble_seq_pkg.sv
// sm83_alu_pkg: shared types and constants for the SM83 nibble-serial ALU.
//   alu_op_t  - 4-bit ALU operation code presented on the request bus
//   state_t   - sequencer states (IDLE, LO nibble, HI nibble)
//   nib_op_t  - function select for the shared 4-bit slice
//   DAA_*     - decimal-adjust correction constants and thresholds
package sm83_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
    OP_AND = 4'd4,  OP_XOR = 4'd5,  OP_OR  = 4'd6,  OP_CP  = 4'd7,
    OP_RLC = 4'd8,  OP_RRC = 4'd9,  OP_RL  = 4'd10, OP_RR  = 4'd11,
    OP_SLA = 4'd12, OP_SRA = 4'd13, OP_SRL = 4'd14, OP_DAA = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NIB_ADD = 3'd0,
    NIB_SUB = 3'd1,
    NIB_AND = 3'd2,
    NIB_XOR = 3'd3,
    NIB_OR  = 3'd4
  } nib_op_t;

  localparam logic [7:0] DAA_CORR_LO = 8'h06;
  localparam logic [7:0] DAA_CORR_HI = 8'h60;
  localparam logic [7:0] DAA_A_MAX   = 8'h99;
  localparam logic [3:0] DAA_NIB_MAX = 4'd9;

  // Rotates and shifts bypass the arithmetic slice.
  function automatic logic is_shift_op(input alu_op_t op);
    logic r;
    case (op)
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: r = 1'b1;
      default:                                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm83_alu_nibble_seq_if.sv
// sm83_alu_nibble_seq_if: request/result bundle of the nibble-serial ALU.
//   master (requester): drives start, op, a_in, b_in, carry_in, daa_half_in,
//                       neg_in; observes busy, done, result and flag outputs.
//   slave  (ALU):       the mirror image.
interface sm83_alu_nibble_seq_if #(parameter int WORD_SIZE = 8);
  import sm83_alu_pkg::*;

  logic                 start;
  alu_op_t              op;
  logic [WORD_SIZE-1:0] a_in;
  logic [WORD_SIZE-1:0] b_in;
  logic                 carry_in;
  logic                 daa_half_in;
  logic                 neg_in;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] result;
  logic                 zero_out;
  logic                 carry_out;
  logic                 half_carry_out;
  logic                 shift_out;
  logic                 daa_carry_out;
  logic                 sign_out;

  modport master (
    output start, op, a_in, b_in, carry_in, daa_half_in, neg_in,
    input  busy, done, result, zero_out, carry_out, half_carry_out,
           shift_out, daa_carry_out, sign_out
  );

  modport slave (
    input  start, op, a_in, b_in, carry_in, daa_half_in, neg_in,
    output busy, done, result, zero_out, carry_out, half_carry_out,
           shift_out, daa_carry_out, sign_out
  );
endinterface

// File: rtl/sm83_alu_nibble_seq_nibble.sv
// sm83_alu_nibble: combinational 4-bit ALU slice.
//   i_a, i_b : nibble operands
//   i_cin    : carry into bit 0 (for NIB_SUB this is the inverted borrow)
//   i_op     : slice function
//   o_res    : nibble result
//   o_cout   : raw carry out of bit 3 (0 for logic functions)
module sm83_alu_nibble
  import sm83_alu_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  nib_op_t    i_op,
  output logic [3:0] o_res,
  output logic       o_cout
);

  logic [4:0] w_sum;

  // Nibble function select; subtraction is a + ~b + cin.
  always_comb begin
    w_sum  = 5'd0;
    o_res  = 4'd0;
    o_cout = 1'b0;
    case (i_op)
      NIB_ADD: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
        o_res  = w_sum[3:0];
        o_cout = w_sum[4];
      end
      NIB_SUB: begin
        w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {4'd0, i_cin};
        o_res  = w_sum[3:0];
        o_cout = w_sum[4];
      end
      NIB_AND: o_res = i_a & i_b;
      NIB_XOR: o_res = i_a ^ i_b;
      NIB_OR:  o_res = i_a | i_b;
      default: o_res = 4'd0;
    endcase
  end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// sm83_alu_nibble_seq: two-phase nibble-serial SM83 ALU datapath.
//   clk, nreset : core clock, asynchronous active-low reset
//   bus (slave) : start/op/operands in; busy, done pulse, result and the
//                 zero/carry/half/shift-out/DAA-carry/sign flags out.
// Sequence: IDLE captures operands on start, LO computes bits 3:0, HI
// computes bits 7:4 with the chained nibble carry and registers everything.
module sm83_alu_nibble_seq
  import sm83_alu_pkg::*;
#(
  parameter int WORD_SIZE = 8
)
(
  input  logic                  clk,
  input  logic                  nreset,
  sm83_alu_nibble_seq_if.slave  bus
);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  alu_op_t              r_op;
  logic                 r_cin;
  logic                 r_dh;
  logic                 r_neg;
  logic [3:0]           r_lo;
  logic                 r_nib_c;
  logic                 r_half_pend;
  logic                 r_busy;
  logic                 r_done;
  logic [WORD_SIZE-1:0] r_result;
  logic                 r_zero;
  logic                 r_carry;
  logic                 r_half;
  logic                 r_sout;
  logic                 r_daac;
  logic                 r_sign;

  logic [7:0]           w_daa_corr;
  logic                 w_daa_c;
  nib_op_t              w_nib_op;
  logic                 w_cin0;
  logic [7:0]           w_b_eff;
  logic [7:0]           w_shift_res;
  logic                 w_shift_bit;
  logic                 w_hi;
  logic [3:0]           w_s_a;
  logic [3:0]           w_s_b;
  logic                 w_s_cin;
  logic [3:0]           w_s_res;
  logic                 w_s_cout;
  logic [3:0]           w_nib_res;
  logic [7:0]           w_result;
  logic                 w_half_lo;
  logic                 w_carry_hi;

  // DAA correction amount and decimal carry, decided from the captured a.
  always_comb begin
    w_daa_corr = 8'h00;
    w_daa_c    = 1'b0;
    if (r_neg) begin
      w_daa_c    = r_cin;
      w_daa_corr = (r_dh ? DAA_CORR_LO : 8'h00) | (r_cin ? DAA_CORR_HI : 8'h00);
    end else begin
      w_daa_c    = r_cin | (r_a > DAA_A_MAX);
      w_daa_corr = ((r_dh | (r_a[3:0] > DAA_NIB_MAX)) ? DAA_CORR_LO : 8'h00) |
                   (w_daa_c ? DAA_CORR_HI : 8'h00);
    end
  end

  // Map the ALU op onto the slice function, effective b and initial carry.
  always_comb begin
    w_nib_op = NIB_ADD;
    w_cin0   = 1'b0;
    w_b_eff  = r_b;
    case (r_op)
      OP_ADD:        w_cin0 = 1'b0;
      OP_ADC:        w_cin0 = r_cin;
      OP_SUB, OP_CP: begin
        w_nib_op = NIB_SUB;
        w_cin0   = 1'b1;
      end
      OP_SBC: begin
        w_nib_op = NIB_SUB;
        w_cin0   = ~r_cin;
      end
      OP_AND:        w_nib_op = NIB_AND;
      OP_XOR:        w_nib_op = NIB_XOR;
      OP_OR:         w_nib_op = NIB_OR;
      OP_DAA: begin
        // Decimal adjust reuses the adder: a +/- correction.
        w_nib_op = r_neg ? NIB_SUB : NIB_ADD;
        w_cin0   = r_neg;
        w_b_eff  = w_daa_corr;
      end
      default:       w_b_eff = 8'h00;
    endcase
  end

  // Whole-word rotate/shift from the captured a; nibbles are picked later.
  always_comb begin
    w_shift_res = 8'h00;
    w_shift_bit = 1'b0;
    case (r_op)
      OP_RLC: begin w_shift_res = {r_a[6:0], r_a[7]}; w_shift_bit = r_a[7]; end
      OP_RL:  begin w_shift_res = {r_a[6:0], r_cin};  w_shift_bit = r_a[7]; end
      OP_SLA: begin w_shift_res = {r_a[6:0], 1'b0};   w_shift_bit = r_a[7]; end
      OP_RRC: begin w_shift_res = {r_a[0], r_a[7:1]}; w_shift_bit = r_a[0]; end
      OP_RR:  begin w_shift_res = {r_cin, r_a[7:1]};  w_shift_bit = r_a[0]; end
      OP_SRA: begin w_shift_res = {r_a[7], r_a[7:1]}; w_shift_bit = r_a[0]; end
      OP_SRL: begin w_shift_res = {1'b0, r_a[7:1]};   w_shift_bit = r_a[0]; end
      default: begin w_shift_res = 8'h00;             w_shift_bit = 1'b0;   end
    endcase
  end

  // Steer the shared slice to the nibble selected by the current state.
  always_comb begin
    w_hi    = (r_state == ST_HI);
    w_s_a   = w_hi ? r_a[7:4]     : r_a[3:0];
    w_s_b   = w_hi ? w_b_eff[7:4] : w_b_eff[3:0];
    w_s_cin = w_hi ? r_nib_c      : w_cin0;
    if (is_shift_op(r_op)) begin
      w_nib_res = w_hi ? w_shift_res[7:4] : w_shift_res[3:0];
    end else begin
      w_nib_res = w_s_res;
    end
    w_result = {w_nib_res, r_lo};
  end

  sm83_alu_nibble u_nibble (
    .i_a    (w_s_a),
    .i_b    (w_s_b),
    .i_cin  (w_s_cin),
    .i_op   (w_nib_op),
    .o_res  (w_s_res),
    .o_cout (w_s_cout)
  );

  // Half flag (from the LO carry) and carry flag (from the HI carry); the
  // subtract family reports borrow, i.e. the inverted carry.
  always_comb begin
    w_half_lo  = 1'b0;
    w_carry_hi = 1'b0;
    case (r_op)
      OP_ADD, OP_ADC: begin
        w_half_lo  = w_s_cout;
        w_carry_hi = w_s_cout;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        w_half_lo  = ~w_s_cout;
        w_carry_hi = ~w_s_cout;
      end
      OP_AND:  w_half_lo = 1'b1;
      default: w_half_lo = 1'b0;
    endcase
  end

  // Sequencer: operand capture, nibble phases and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_cin       <= 1'b0;
      r_dh        <= 1'b0;
      r_neg       <= 1'b0;
      r_lo        <= 4'd0;
      r_nib_c     <= 1'b0;
      r_half_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_half      <= 1'b0;
      r_sout      <= 1'b0;
      r_daac      <= 1'b0;
      r_sign      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_op    <= bus.op;
            r_cin   <= bus.carry_in;
            r_dh    <= bus.daa_half_in;
            r_neg   <= bus.neg_in;
            r_busy  <= 1'b1;
            r_state <= ST_LO;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_LO: begin
          r_lo        <= w_nib_res;
          r_nib_c     <= w_s_cout;
          r_half_pend <= w_half_lo;
          r_state     <= ST_HI;
        end
        ST_HI: begin
          r_result <= w_result;
          r_zero   <= (w_result == 8'h00);
          r_sign   <= w_result[7];
          r_carry  <= w_carry_hi;
          r_half   <= r_half_pend;
          r_sout   <= w_shift_bit;
          r_daac   <= (r_op == OP_DAA) ? w_daa_c : 1'b0;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.result         = r_result;
  assign bus.zero_out       = r_zero;
  assign bus.carry_out      = r_carry;
  assign bus.half_carry_out = r_half;
  assign bus.shift_out      = r_sout;
  assign bus.daa_carry_out  = r_daac;
  assign bus.sign_out       = r_sign;

endmodule

// File: tb/tb_sm83_alu_nibble_seq.sv
// Self-checking bench for sm83_alu_nibble_seq: directed cases, timing
// scenarios (held start, start during LO, reset during HI) and random ops
// compared against an arithmetic reference model.
module tb_sm83_alu_nibble_seq;
  import sm83_alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       z, c, h, so, dc, s;
  } exp_t;

  logic clk;
  logic nreset;
  int   n_vec;
  int   n_cmp;
  int   n_err;

  sm83_alu_nibble_seq_if #(.WORD_SIZE(8)) bus ();

  sm83_alu_nibble_seq #(.WORD_SIZE(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour from the instruction definitions, in integer math.
  function automatic exp_t model(input alu_op_t op, input logic [7:0] av,
                                 input logic [7:0] bv, input logic cv,
                                 input logic dhv, input logic ngv);
    exp_t e;
    int a, b, c, r, adj;
    a = {24'd0, av};
    b = {24'd0, bv};
    c = {31'd0, cv};
    e = '0;
    r = 0;
    adj = 0;
    case (op)
      OP_ADD: begin r = a + b;     e.c = (r > 255); e.h = ((a % 16) + (b % 16)) > 15; end
      OP_ADC: begin r = a + b + c; e.c = (r > 255); e.h = ((a % 16) + (b % 16) + c) > 15; end
      OP_SUB, OP_CP: begin r = a - b; e.c = (a < b); e.h = ((a % 16) < (b % 16)); end
      OP_SBC: begin r = a - b - c; e.c = (a < b + c); e.h = ((a % 16) < (b % 16) + c); end
      OP_AND: begin r = a & b; e.h = 1'b1; end
      OP_XOR: r = a ^ b;
      OP_OR:  r = a | b;
      OP_RLC: begin r = a * 2 + a / 128;         e.so = (a >= 128); end
      OP_RL:  begin r = a * 2 + c;               e.so = (a >= 128); end
      OP_SLA: begin r = a * 2;                   e.so = (a >= 128); end
      OP_RRC: begin r = a / 2 + (a % 2) * 128;   e.so = (a % 2 == 1); end
      OP_RR:  begin r = a / 2 + c * 128;         e.so = (a % 2 == 1); end
      OP_SRA: begin r = a / 2 + (a / 128) * 128; e.so = (a % 2 == 1); end
      OP_SRL: begin r = a / 2;                   e.so = (a % 2 == 1); end
      OP_DAA: begin
        if (!ngv) begin
          if (dhv || (a % 16) > 9) adj = adj + 6;
          if (cv || a > 153) begin adj = adj + 96; e.dc = 1'b1; end
          r = a + adj;
        end else begin
          if (dhv) adj = adj + 6;
          if (cv)  adj = adj + 96;
          r = a - adj;
          e.dc = cv;
        end
      end
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    e.res = r[7:0];
    e.z = (e.res == 8'h00);
    e.s = e.res[7];
    return e;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input exp_t e);
    chk8({tag, "_result"}, bus.result,         e.res);
    chk1({tag, "_zero"},   bus.zero_out,       e.z);
    chk1({tag, "_carry"},  bus.carry_out,      e.c);
    chk1({tag, "_half"},   bus.half_carry_out, e.h);
    chk1({tag, "_shift"},  bus.shift_out,      e.so);
    chk1({tag, "_daac"},   bus.daa_carry_out,  e.dc);
    chk1({tag, "_sign"},   bus.sign_out,       e.s);
  endtask

  task automatic drive(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic dh, input logic ng);
    bus.op          = op;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.carry_in    = c;
    bus.daa_half_in = dh;
    bus.neg_in      = ng;
  endtask

  task automatic scramble();
    drive(alu_op_t'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One full operation: latency, busy, outputs, and hold in the next cycle.
  task automatic do_op(input string tag, input alu_op_t op, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic dh,
                       input logic ng);
    exp_t e;
    int   lat;
    e = model(op, a, b, c, dh, ng);
    n_vec++;
    @(negedge clk);
    drive(op, a, b, c, dh, ng);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    chk1({tag, "_busy_c1"}, bus.busy, 1'b1);
    chk1({tag, "_done_c1"}, bus.done, 1'b0);
    lat = 0;
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk8({tag, "_latency"}, 8'(lat), 8'd3);
    chk_flags(tag, e);
    @(posedge clk);
    #1;
    chk1({tag, "_done_pulse"}, bus.done, 1'b0);
    chk8({tag, "_hold"}, bus.result, e.res);
  endtask

  initial begin
    exp_t e1;
    n_vec = 0;
    n_cmp = 0;
    n_err = 0;
    nreset = 1'b0;
    bus.start = 1'b0;
    drive(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state.
    #22;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk8("rst_result", bus.result, 8'h00);
    chk1("rst_zero", bus.zero_out, 1'b0);
    chk1("rst_carry", bus.carry_out, 1'b0);
    chk1("rst_half", bus.half_carry_out, 1'b0);
    chk1("rst_daac", bus.daa_carry_out, 1'b0);
    @(negedge clk);
    nreset = 1'b1;

    // Directed operations.
    do_op("add_3a_c6", OP_ADD, 8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0);
    do_op("sbc_10_01", OP_SBC, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
    do_op("daa_3c",    OP_DAA, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op("daa_9a",    OP_DAA, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op("daa_neg",   OP_DAA, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b1);
    do_op("rl_80",     OP_RL,  8'h80, 8'h55, 1'b0, 1'b0, 1'b0);
    do_op("sra_81",    OP_SRA, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
    do_op("cp_eq",     OP_CP,  8'h42, 8'h42, 1'b1, 1'b0, 1'b0);
    do_op("adc_ff",    OP_ADC, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);

    // start held high: done in cycles 3, 6, 9.
    e1 = model(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk1("hold_done_c1", bus.done, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("hold_done_c%0d", k), bus.done, (k % 3) == 0);
      if ((k % 3) == 0) begin
        chk8($sformatf("hold_result_c%0d", k), bus.result, e1.res);
        n_vec++;
      end
      if (k == 9) bus.start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk1("hold_idle_busy", bus.busy, 1'b0);

    // start pulsed during LO is ignored.
    e1 = model(OP_XOR, 8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(OP_XOR, 8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    drive(OP_SUB, 8'h01, 8'h99, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk1("ignlo_done", bus.done, 1'b1);
    chk8("ignlo_result", bus.result, e1.res);
    for (int k = 4; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("ignlo_nodone_c%0d", k), bus.done, 1'b0);
      chk1($sformatf("ignlo_busy_c%0d", k), bus.busy, 1'b0);
    end

    // Reset during HI aborts the operation.
    @(negedge clk);
    drive(OP_OR, 8'h81, 8'h18, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_vec++;
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_done", bus.done, 1'b0);
    chk8("abort_result", bus.result, 8'h00);
    chk1("abort_sign", bus.sign_out, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("abort_nodone_%0d", k), bus.done, 1'b0);
      chk1($sformatf("abort_nobusy_%0d", k), bus.busy, 1'b0);
    end
    do_op("after_abort", OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 150; i++) begin
      do_op($sformatf("rnd%0d", i), alu_op_t'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
